// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered occupancy flags and sticky error bits.
// Pointers carry one extra wrap bit so all DEPTH entries are usable.
module sync_fifo_flags #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
   logic ovf_q, ovf_d, unf_q, unf_d;
   logic wa, ra;

   // clr wins over both requests; nothing is accepted while held in reset
   always_comb begin
      wa      = rstn && wr_en && !full_q && !clr;
      ra      = rstn && rd_en && !empty_q && !clr;
      wptr_d  = clr ? '0 : wptr_q + PW'(wa);
      rptr_d  = clr ? '0 : rptr_q + PW'(ra);
      count_d = clr ? '0 : count_q + CW'(wa) - CW'(ra);
      empty_d = wptr_d == rptr_d;
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      af_d    = count_d >= AF_L;
      ae_d    = count_d <= AE_L;
      ovf_d   = !clr && (ovf_q || (wr_en && full_q));
      unf_d   = !clr && (unf_q || (rd_en && empty_q));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk)
      if (wa) mem[wptr_q[AW-1:0]] <= wdata;

   if (FWFT != 0) begin : g_fwft
      assign rdata = mem[rptr_q[AW-1:0]];
   end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) rdata_q <= '0;
         else if (ra) rdata_q <= mem[rptr_q[AW-1:0]];
      assign rdata = rdata_q;
   end

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, meaning almost_full threshold, range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning almost_empty threshold, range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-007 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port clr, input, 1, meaning synchronous flush, active-high.
REQ-009 SHALL have port wr_en, input, 1, meaning write request.
REQ-010 SHALL have port wdata, input, WIDTH, meaning write data.
REQ-011 SHALL have port rd_en, input, 1, meaning read request.
REQ-012 SHALL have port rdata, output, WIDTH, meaning read data.
REQ-013 SHALL have port full, output, 1, meaning count == DEPTH.
REQ-014 SHALL have port empty, output, 1, meaning count == 0.
REQ-015 SHALL have port almost_full, output, 1, meaning count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty, output, 1, meaning count <= AE_LEVEL.
REQ-017 SHALL have port count, output, $clog2(DEPTH+1), meaning current occupancy 0..DEPTH.
REQ-018 SHALL have port overflow, output, 1, meaning sticky: write attempted while full.
REQ-019 SHALL have port underflow, output, 1, meaning sticky: read attempted while empty.

Function
REQ-020 Pointers SHALL be $clog2(DEPTH)+1 bits wide; full/empty derived from the extra MSB, so all DEPTH entries are usable.
REQ-021 Write accepted iff wr_en && !full at the edge: mem[wptr] <= wdata, wptr increments, wrapping modulo 2*DEPTH.
REQ-022 Read accepted iff rd_en && !empty at the edge: rptr increments, wrapping identically.
REQ-023 Simultaneous accepted read and write SHALL leave count unchanged; when full, write is rejected even if rd_en is asserted in the same cycle.
REQ-024 count, full, empty, almost_full and almost_empty SHALL be registered and reflect the post-edge occupancy in the cycle after the edge.
REQ-025 FWFT=0: on an accepted read, rdata <= mem[rptr] at that edge (1-cycle latency); rdata holds its value otherwise.
REQ-026 FWFT=1: rdata SHALL combinationally present mem[rptr] whenever !empty; an accepted read advances to the next word; rdata is don't-care while empty.
REQ-027 FWFT=1: a word written into an empty FIFO SHALL appear on rdata with empty deasserted one cycle after the write edge.
REQ-028 overflow SHALL set on any edge where wr_en && full, and underflow on any edge where rd_en && empty; both hold until clr or reset.
REQ-029 A rejected request SHALL not modify memory, pointers, count or rdata.
REQ-030 clr=1 SHALL, at the edge, zero both pointers and count, set empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), and clear overflow/underflow; clr has priority over wr_en/rd_en in that cycle.
REQ-031 Memory contents SHALL not be reset or cleared.

Reset
REQ-032 rstn=0 SHALL immediately, independent of clk, force: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0 (FWFT=0).
REQ-033 Reset asserted mid-operation SHALL discard all stored words; the first read after release returns the first word written after release.
REQ-034 Deassertion of rstn SHALL take effect on the first rising clk edge that follows it; no request is accepted while rstn=0.

Verification
REQ-035 Defaults, FWFT=0: write 8 words 0x01..0x08 -> full=1, count=8, almost_full=1 after the 7th write; 9th write -> overflow=1, count stays 8; 8 reads return 0x01..0x08 in order, each 1 cycle after rd_en.
REQ-036 FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0, rdata=0xA5 with no rd_en; rd_en for 1 cycle -> empty=1.
REQ-037 Count 4, wr_en=rd_en=1 for 10 cycles -> count stays 4, data order preserved across pointer wrap; with full, simultaneous rd/wr -> read accepted, write rejected, count 7, overflow=1.
REQ-038 Read from empty after reset -> underflow=1, rdata unchanged, count 0; clr pulse -> underflow=0, empty=1.
REQ-039 At count 5, assert rstn=0 asynchronously between edges -> outputs at reset values before the next edge; after release write 0x3C, read -> 0x3C.
REQ-040 AF_LEVEL=6, AE_LEVEL=2: sweep count 0..8..0 -> almost_empty=1 exactly for count<=2, almost_full=1 exactly for count>=6.
